// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
// Holds the FSM state type, BCD digit constants and a digit validity check.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;

  localparam logic [BCD_W-1:0] BCD_MAX         = 4'd9;
  localparam logic [BCD_W-1:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [BCD_W-1:0] BCD_CORR        = 4'd3;

  // True when a 4-bit code is a legal decimal digit.
  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One reverse double-dabble correction cell.
// Ports: din  - shifted BCD digit
//        dout - din minus 3 when din >= 8, else din (4-bit, no borrow out)
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= BCD_CORR_THRESH) ? BCD_W'(din - BCD_CORR) : din;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right,
// subtract 3 on any digit that reaches 8). One iteration per clock, BIN_W
// iterations per conversion.
// Ports: clk, rst (async active-high)
//        start              - request conversion, sampled in IDLE only
//        thou/hund/tens/uni - BCD digits, sampled on the accepted start edge
//        busy               - conversion in progress
//        done               - one-cycle pulse when num/err update
//        err                - a sampled digit was > 9 (held until next completion)
//        num                - binary result (held until next completion)
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       thou,
  input  logic [3:0]       hund,
  input  logic [3:0]       tens,
  input  logic [3:0]       uni,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] num
);

  localparam int unsigned SH_W  = BCD_DIGITS * BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   num_q, num_d;

  logic [SH_W-1:0]    sh_shift;
  logic [SH_W-1:0]    sh_corr;
  logic [BCD_W-1:0]   dig_shift [BCD_DIGITS];
  logic [BCD_W-1:0]   dig_corr  [BCD_DIGITS];
  logic               digits_ok;

  // Whole register shifts right; units LSB falls into the binary MSB.
  assign sh_shift = sh_q >> 1;

  // Independent per-digit correction after the shift.
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    assign dig_shift[i] = sh_shift[BIN_W + i*BCD_W +: BCD_W];
    bcd_digit_sub3 u_sub3 (
      .din  (dig_shift[i]),
      .dout (dig_corr[i])
    );
  end

  // Reassemble the iterated value: corrected digits over the untouched binary field.
  always_comb begin
    sh_corr = sh_shift;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      sh_corr[BIN_W + i*BCD_W +: BCD_W] = dig_corr[i];
    end
  end

  assign digits_ok = is_bcd(thou) && is_bcd(hund) && is_bcd(tens) && is_bcd(uni);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    num_d   = num_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (digits_ok) begin
            sh_d    = {thou, hund, tens, uni, {BIN_W{1'b0}}};
            cnt_d   = CNT_W'(BIN_W);
            busy_d  = 1'b1;
            state_d = CONV;
          end else begin
            // Bad digit: report immediately without running the shifter.
            err_d  = 1'b1;
            num_d  = '0;
            done_d = 1'b1;
          end
        end
      end
      CONV: begin
        sh_d  = sh_corr;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          num_d   = sh_corr[BIN_W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      num_q   <= num_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign num  = num_q;

endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
- Sequential BCD-to-binary converter for the calculator datapath, using the reverse double-dabble algorithm (shift right, subtract 3).
- Inverse of the combinational binary-to-BCD converter.
- Takes four BCD digits (thousands, hundreds, tens, units) entered from the keypad/display path and produces a 14-bit unsigned binary operand for the ALU.
- Uses a start/done handshake. Conversion takes BIN_W clock iterations.

Parameters:
- BIN_W, 14, width of the binary result and the number of shift iterations. Must be at least 14 so that 9999 fits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request conversion. Sampled only in IDLE.
- thou  in  4  BCD thousands digit. Sampled on the accepted start edge.
- hund  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- uni  in  4  BCD units digit.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when num/err are updated.
- err  out  1  set if any sampled digit was >9. Held until the next completion.
- num  out  BIN_W  binary result. Held until the next completion.

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - State goes to IDLE.
  - busy=0, done=0, err=0, num=0, iteration counter=0, shift register=0.
  - Any in-flight conversion is discarded; no done pulse is produced for it.
- FSM states: IDLE, CONV.
- IDLE, on an edge with start=1:
  - If all four digits are ≤9: load shift register {thou,hund,tens,uni, BIN_W zeros}, set counter=BIN_W, busy=1, go to CONV.
  - If any digit is >9: stay in IDLE; at that same edge set err=1, num=0, done=1 (1-cycle latency). No conversion is run.
- CONV, each edge performs one iteration:
  - Logically shift the full (16+BIN_W)-bit register right by 1. Units LSB enters binary MSB; zero enters thou MSB.
  - Then, on each of the four shifted digits independently: if digit ≥8, subtract 3 (4-bit result, no borrow between digits).
  - Decrement counter.
- On the edge where counter goes 1→0:
  - num ← binary field of the iterated value.
  - err ← 0, done ← 1, busy ← 0, go to IDLE.
- Latency: start accepted at edge k → num valid and done=1 in the cycle after edge k+BIN_W. busy is high during cycles k+1 … k+BIN_W.
- done is high exactly one cycle. It is cleared on the next edge unless a new invalid-digit start raises it again.
- start while busy=1: ignored, not queued. Digit inputs are don't-care after the load edge.
- Back-to-back operation: start high during the done cycle is accepted at the next edge. No dead cycle is required.
- start held high continuously: a new conversion begins in every IDLE cycle.
- Arithmetic: all unsigned. Maximum result 9999 = 14'h270F. Leading zero digits are legal.
- num and err change only on a completion edge or on reset.

Decomposition:
- Shared package bcd_pkg holds:
  - State enum {IDLE, CONV}.
  - Constants BCD_DIGITS=4, BCD_W=4, BCD_MAX=9, BCD_CORR_THRESH=8, BCD_CORR=3.
  - Function is_bcd(4-bit).
- One sub-module, bcd_digit_sub3: combinational 4-bit, out = (in≥8) ? in−3 : in. Instantiated four times on the shifted digits.

Test Plan:
- Digits 0,0,0,0, start pulse → after BIN_W+1 cycles done=1 for one cycle, num=0, err=0; busy high for exactly 14 cycles.
- Digits 9,9,9,9 → num=9999 (14'h270F), err=0. Then digits 1,2,3,4 started in the done cycle → num=1234 (14'h04D2) with no idle gap.
- Digits 0,0,1,0 then 0,5,0,7 → num=10 then num=507. num holds 10 throughout the second conversion until its done edge.
- tens=4'hA, start → done=1 and err=1 in the cycle after the start edge, num=0, busy never asserted. A following valid 0,0,4,2 → err=0, num=42.
- Start 1,2,3,4, then pulse start with 8,8,8,8 at cycle 5 while busy → ignored; num=1234, only one done pulse.
- Start 9,9,9,9, assert rst asynchronously (between edges) at iteration 7 → busy, done, err, num go to 0 immediately. After release, no spurious done; a new start 0,0,0,1 gives num=1.
